// File: rtl/fnn_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fnn_ctrl_pkg                                                    |
// | Brief    : Shared types and width helpers for the layer sequencer.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package fnn_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_WAIT   = 2'd2,
    S_DRAIN  = 2'd3
  } seq_state_t;

  localparam int unsigned OUT_LAYER_W = 32;

  // Bits needed to hold every value in 0..max_val, never less than one.
  function automatic int unsigned bits_for(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/layer_result_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : layer_result_buf                                                |
// | Brief    : Per-neuron activation capture registers, sticky flags, read mux.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module layer_result_buf #(
  parameter int unsigned NUM_NEURON = 10,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cap_en_i,
  input  logic                             clr_i,
  input  logic [NUM_NEURON-1:0]            outvalid_i,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0] act_i,
  input  logic [IDX_W-1:0]                 idx_i,
  output logic                             all_got_o,
  output logic [DATA_WIDTH-1:0]            rd_data_o
);

  logic [DATA_WIDTH-1:0] w_act [NUM_NEURON];
  logic [DATA_WIDTH-1:0] res_q [NUM_NEURON];
  logic [DATA_WIDTH-1:0] res_d [NUM_NEURON];
  logic [NUM_NEURON-1:0] got_q;
  logic [NUM_NEURON-1:0] got_d;
  logic [NUM_NEURON-1:0] w_hit;

  for (genvar k = 0; k < NUM_NEURON; k++) begin : g_slice
    assign w_act[k] = act_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_hit     = outvalid_i & {NUM_NEURON{cap_en_i}};
  // Same-cycle arrivals count, so the last flag lets the FSM leave WAIT at once.
  assign all_got_o = &(got_q | w_hit);

  always_comb begin
    got_d = got_q;
    res_d = res_q;
    for (int k = 0; k < NUM_NEURON; k++) begin
      if (w_hit[k]) begin
        res_d[k] = w_act[k];
        got_d[k] = 1'b1;
      end
    end
    if (clr_i) begin
      got_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      got_q <= '0;
      for (int k = 0; k < NUM_NEURON; k++) begin
        res_q[k] <= '0;
      end
    end else begin
      got_q <= got_d;
      res_q <= res_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < NUM_NEURON; k++) begin
      if (idx_i == IDX_W'(k)) begin
        rd_data_o = res_q[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : layer_sequencer                                                 |
// | Brief    : Broadcasts one input frame to a layer of neurons, collects the  |
// |            activations and serializes them downstream.                     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module layer_sequencer
  import fnn_ctrl_pkg::*;
#(
  parameter int layerNo     = 1,
  parameter int numNeuron   = 10,
  parameter int numWeight   = 784,
  parameter int dataWidth   = 16,
  parameter int waitTimeout = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [dataWidth-1:0]           in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [dataWidth-1:0]           nrn_data,
  output logic                           nrn_valid,
  input  logic [numNeuron*dataWidth-1:0] nrn_out,
  input  logic [numNeuron-1:0]           nrn_outvalid,
  output logic [dataWidth-1:0]           out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_LAYER_W-1:0]         out_layer,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int unsigned CNT_W = bits_for(numWeight);
  localparam int unsigned TMO_W = bits_for(waitTimeout);
  localparam int unsigned IDX_W = bits_for(numNeuron - 1);

  localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(numWeight - 1);
  localparam logic [TMO_W-1:0] LAST_TMO = TMO_W'(waitTimeout - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(numNeuron - 1);
  localparam bit               ONE_SMP  = (numWeight == 1);

  seq_state_t           state_q, state_d;
  logic [CNT_W-1:0]     smp_cnt_q, smp_cnt_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 busy_q;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 nrn_valid_q;
  logic [dataWidth-1:0] nrn_data_q;

  logic                 w_accept;
  logic                 w_clr;
  logic                 w_cap_en;
  logic                 w_all_got;
  logic [dataWidth-1:0] w_rd_data;

  assign w_accept = in_valid & in_ready;
  assign w_cap_en = (state_q == S_WAIT);

  layer_result_buf #(
    .NUM_NEURON (numNeuron),
    .DATA_WIDTH (dataWidth),
    .IDX_W      (IDX_W)
  ) u_result_buf (
    .clk        (clk),
    .rst        (rst),
    .cap_en_i   (w_cap_en),
    .clr_i      (w_clr),
    .outvalid_i (nrn_outvalid),
    .act_i      (nrn_out),
    .idx_i      (idx_q),
    .all_got_o  (w_all_got),
    .rd_data_o  (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      smp_cnt_q <= '0;
      tmo_cnt_q <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      smp_cnt_q <= smp_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      idx_q     <= idx_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    smp_cnt_d = smp_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    w_clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (ONE_SMP) begin
            state_d = S_WAIT;
          end else begin
            state_d   = S_STREAM;
            smp_cnt_d = CNT_W'(1);
          end
        end
      end
      S_STREAM: begin
        if (w_accept) begin
          if (smp_cnt_q == LAST_SMP) begin
            state_d   = S_WAIT;
            smp_cnt_d = '0;
          end else begin
            smp_cnt_d = smp_cnt_q + CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        // A complete result set wins over a timeout landing in the same cycle.
        if (w_all_got) begin
          state_d   = S_DRAIN;
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == LAST_TMO) begin
          state_d   = S_IDLE;
          tmo_cnt_d = '0;
          err_d     = 1'b1;
          w_clr     = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
            w_clr   = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    unique case (state_q)
      S_IDLE, S_STREAM: begin
        in_ready = 1'b1;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_data  = w_rd_data;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Broadcast registers: one pulse per accepted sample, data held between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      nrn_valid_q <= 1'b0;
      nrn_data_q  <= '0;
    end else begin
      nrn_valid_q <= w_accept;
      if (w_accept) begin
        nrn_data_q <= in_data;
      end
    end
  end

  assign nrn_valid = nrn_valid_q;
  assign nrn_data  = nrn_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign out_layer = OUT_LAYER_W'(layerNo);

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_layer_sequencer                                              |
// | Brief    : Directed bench for layer_sequencer with a small neuron model.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_layer_sequencer;

  localparam int NN = 3;
  localparam int NW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] nrn_data;
  logic          nrn_valid;
  logic [NN*DW-1:0] nrn_out;
  logic [NN-1:0] nrn_outvalid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_layer;
  logic          busy;
  logic          done;
  logic          err;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Neuron model controls, written by the stimulus process between frames.
  logic [DW-1:0] val [NN];
  int            dly [NN];
  bit            en  [NN];
  logic [NN-1:0] inj;
  logic [NN-1:0] fire;
  int            ncnt [NN];
  int            tmr  [NN];

  always #5 clk = ~clk;

  layer_sequencer #(
    .layerNo     (3),
    .numNeuron   (NN),
    .numWeight   (NW),
    .dataWidth   (DW),
    .waitTimeout (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .nrn_data     (nrn_data),
    .nrn_valid    (nrn_valid),
    .nrn_out      (nrn_out),
    .nrn_outvalid (nrn_outvalid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_layer    (out_layer),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  assign nrn_out      = {val[2], val[1], val[0]};
  assign nrn_outvalid = fire | inj;

  // Each neuron fires outvalid for one cycle, dly cycles after its 4th input.
  always @(negedge clk) begin
    for (int k = 0; k < NN; k++) begin
      fire[k] = 1'b0;
      if (rst) begin
        ncnt[k] = 0;
        tmr[k]  = 0;
      end else begin
        if (tmr[k] > 0) begin
          tmr[k] = tmr[k] - 1;
          if (tmr[k] == 0) fire[k] = en[k];
        end
        if (nrn_valid) begin
          ncnt[k] = ncnt[k] + 1;
          if (ncnt[k] == NW) begin
            ncnt[k] = 0;
            tmr[k]  = dly[k];
          end
        end
      end
    end
  end

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          e_ir;
    logic          e_nv;
    logic [DW-1:0] e_nd;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic          e_busy;
    logic          e_done;
    logic          e_err;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_frame(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                            input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    logic [DW-1:0] d [4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = d[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input int bound);
    int n;
    n = 0;
    while (!out_valid && n < bound) begin
      tick();
      n++;
    end
    check("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic drain_check(input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                             input logic [DW-1:0] e2);
    logic [DW-1:0] e [3];
    e = '{e0, e1, e2};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drain.ov%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("drain.od%0d", i), 32'(out_data), 32'(e[i]));
      check($sformatf("drain.done%0d", i), 32'(done), 32'd0);
      tick();
    end
    check("drain.done", 32'(done), 32'd1);
    check("drain.ov_end", 32'(out_valid), 32'd0);
    check("drain.in_ready_end", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    tick();
    check("drain.done_clear", 32'(done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    bit            ivp [6];
    logic          rp [5];
    logic [DW-1:0] ed [5];
    int            npulse;
    int            n;
    bit            saw_ov;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    inj       = '0;
    for (int k = 0; k < NN; k++) begin
      val[k] = '0;
      dly[k] = 5;
      en[k]  = 1'b1;
    end

    // Frame 1: contiguous stream, staggered outvalid (k=2, then k=0/1 together).
    //         iv   id        rdy  ir   nv   nd        ov   od        busy done err
    vecs[0]  = '{1'b1, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 16'h0002, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 16'h0003, 1'b1, 1'b1, 1'b1, 16'h0003, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 16'h0004, 1'b1, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    for (int i = 4; i < 10; i++)
      vecs[i] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0200, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0300, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

    tick();
    tick();
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.nrn_valid", 32'(nrn_valid), 32'd0);
    check("rst.nrn_data", 32'(nrn_data), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_data", 32'(out_data), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("out_layer", out_layer, 32'd3);
    rst = 1'b0;

    val[0] = 16'h0100; val[1] = 16'h0200; val[2] = 16'h0300;
    dly[0] = 6; dly[1] = 6; dly[2] = 5;
    for (int i = 0; i < 15; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      out_ready = vecs[i].ordy;
      tick();
      check($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      check($sformatf("v%0d.nrn_valid", i), 32'(nrn_valid), 32'(vecs[i].e_nv));
      if (vecs[i].e_nv)
        check($sformatf("v%0d.nrn_data", i), 32'(nrn_data), 32'(vecs[i].e_nd));
      check($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d.out_data", i), 32'(out_data), 32'(vecs[i].e_od));
      check($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("v%0d.done", i), 32'(done), 32'(vecs[i].e_done));
      check($sformatf("v%0d.err", i), 32'(err), 32'(vecs[i].e_err));
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Downstream backpressure 1,0,0,1,1 during DRAIN.
    val[0] = 16'h00A1; val[1] = 16'h00B2; val[2] = 16'h00C3;
    for (int k = 0; k < NN; k++) dly[k] = 5;
    send_frame(16'h0010, 16'h0020, 16'h0030, 16'h0040);
    wait_out_valid(30);
    check("bp.first", 32'(out_data), 32'h00A1);
    rp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    ed = '{16'h00B2, 16'h00B2, 16'h00B2, 16'h00C3, 16'h0000};
    for (int i = 0; i < 5; i++) begin
      out_ready = rp[i];
      tick();
      check($sformatf("bp.od%0d", i), 32'(out_data), 32'(ed[i]));
      check($sformatf("bp.ov%0d", i), 32'(out_valid), 32'(i != 4));
      check($sformatf("bp.done%0d", i), 32'(done), 32'(i == 4));
    end
    out_ready = 1'b0;
    tick();

    // Neuron 1 silent: timeout after 8 WAIT cycles, then a normal frame.
    en[1] = 1'b0;
    send_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    for (int t = 1; t <= 9; t++) begin
      tick();
      check($sformatf("to.err%0d", t), 32'(err), 32'(t == 8));
      check($sformatf("to.ov%0d", t), 32'(out_valid), 32'd0);
      if (t == 8) begin
        check("to.busy", 32'(busy), 32'd0);
        check("to.in_ready", 32'(in_ready), 32'd1);
      end
    end
    en[1] = 1'b1;
    val[0] = 16'h0AAA; val[1] = 16'h0BBB; val[2] = 16'h0CCC;
    send_frame(16'h0005, 16'h0006, 16'h0007, 16'h0008);
    wait_out_valid(30);
    drain_check(16'h0AAA, 16'h0BBB, 16'h0CCC);

    // Gapped stream plus an outvalid injected during STREAM that must be ignored.
    en[0]  = 1'b0;
    ivp    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    d      = 16'h0011;
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = ivp[i];
      in_data  = d;
      inj      = (i == 1) ? 3'b001 : 3'b000;
      tick();
      check($sformatf("gap.nv%0d", i), 32'(nrn_valid), 32'(ivp[i]));
      if (nrn_valid) npulse++;
      if (ivp[i]) begin
        check($sformatf("gap.nd%0d", i), 32'(nrn_data), 32'(d));
        d = d + 16'h0011;
      end
    end
    in_valid = 1'b0;
    inj      = '0;
    check("gap.pulses", 32'(npulse), 32'd4);
    n      = 0;
    saw_ov = 1'b0;
    while (!err && n < 20) begin
      tick();
      n++;
      if (out_valid) saw_ov = 1'b1;
    end
    check("inj.err", 32'(err), 32'd1);
    check("inj.wait_cycles", 32'(n), 32'd8);
    check("inj.no_out_valid", 32'(saw_ov), 32'd0);
    en[0] = 1'b1;
    tick();

    // Reset after the second sample, then a fresh frame.
    val[0] = 16'h0111; val[1] = 16'h0222; val[2] = 16'h0333;
    in_valid = 1'b1;
    in_data  = 16'h0001;
    tick();
    in_data = 16'h0002;
    tick();
    in_data = 16'h0003;
    rst     = 1'b1;
    tick();
    check("mrst.in_ready", 32'(in_ready), 32'd1);
    check("mrst.nrn_valid", 32'(nrn_valid), 32'd0);
    check("mrst.nrn_data", 32'(nrn_data), 32'd0);
    check("mrst.out_valid", 32'(out_valid), 32'd0);
    check("mrst.out_data", 32'(out_data), 32'd0);
    check("mrst.busy", 32'(busy), 32'd0);
    check("mrst.done", 32'(done), 32'd0);
    check("mrst.err", 32'(err), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    send_frame(16'h0005, 16'h0006, 16'h0007, 16'h0008);
    wait_out_valid(30);
    drain_check(16'h0111, 16'h0222, 16'h0333);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/layer_sequencer.md
# layer_sequencer

Per-layer controller for one fully connected layer of neuron instances. It accepts one input frame of `numWeight` samples from upstream and broadcasts it to every neuron of the layer. It then waits until every neuron reports `outvalid`, captures the `numNeuron` activations, and serializes them downstream. It sits between consecutive layers and guarantees that a neuron never receives a new frame before it has finished the previous one.

## Interface
Parameters:
- `layerNo`, 1: layer index, reported on `out_layer`.
- `numNeuron`, 10: neurons in this layer.
- `numWeight`, 784: samples per input frame, equal to the neurons' weight count.
- `dataWidth`, 16: sample and activation width.
- `waitTimeout`, 64: maximum cycles in WAIT before the frame is aborted.

Ports:
- `clk`, in, 1: single clock. Everything is sampled on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_data`, in, `dataWidth`: upstream sample.
- `in_valid`, in, 1: upstream sample valid.
- `in_ready`, out, 1: block accepts a sample this cycle.
- `nrn_data`, out, `dataWidth`: broadcast to every neuron's `myinput`.
- `nrn_valid`, out, 1: broadcast to every neuron's `myinputValid`.
- `nrn_out`, in, `numNeuron*dataWidth`: neuron activations. Neuron k occupies bits [k*dataWidth +: dataWidth].
- `nrn_outvalid`, in, `numNeuron`: per-neuron `outvalid`.
- `out_data`, out, `dataWidth`: serialized activation.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: downstream accepts.
- `out_layer`, out, 32: constant `layerNo`.
- `busy`, out, 1: state is not IDLE.
- `done`, out, 1: one-cycle pulse after the last activation is accepted.
- `err`, out, 1: one-cycle pulse on a WAIT timeout.

## Operation
States: IDLE, STREAM, WAIT, DRAIN.

- **IDLE**
  - `in_ready`=1.
  - When a sample is accepted (`in_valid & in_ready`), it becomes sample 0 and the state moves to STREAM.
  - If `numWeight`==1, the state moves directly to WAIT.
- **STREAM**
  - `in_ready`=1. A sample counter of width $clog2(numWeight+1) increments per accepted sample.
  - Gaps in `in_valid` are allowed; `nrn_valid` simply deasserts during a gap.
  - When sample `numWeight`-1 is accepted, the state moves to WAIT and `in_ready` drops the next cycle.
- **Broadcast datapath** (IDLE and STREAM)
  - `nrn_data` and `nrn_valid` are registered copies of the accepted sample and of the accept strobe.
  - `nrn_valid` is never asserted outside accepted samples. Exactly `numWeight` pulses are issued per frame.
- **WAIT**
  - `in_ready`=0.
  - On `nrn_outvalid[k]`, the block captures `nrn_out` slice k into `res[k]` and sets sticky flag `got[k]`.
  - Captures only occur in WAIT. Any `nrn_outvalid` in other states is ignored.
  - A repeated `outvalid` from a neuron whose flag is already set overwrites `res[k]`.
  - When all flags are set, including bits arriving in the same cycle, the state moves to DRAIN.
  - The timeout counter increments every WAIT cycle. When it reaches `waitTimeout`, the block pulses `err`, clears all flags and returns to IDLE with no output.
- **DRAIN**
  - `out_valid`=1 and `out_data`=`res[idx]`, with `idx` starting at 0.
  - On `out_ready`, `idx` increments. After `idx`=`numNeuron`-1 is accepted, the block pulses `done`, clears flags, `idx` and the counters, and returns to IDLE.
  - `out_data` and `out_valid` hold stable while `out_ready`=0.
- **Reset**, including mid-frame:
  - State returns to IDLE; all counters, flags and `res` are cleared.
  - Output values: `in_ready`=1, `nrn_valid`=0, `nrn_data`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `err`=0.
  - A partial frame already sent to the neurons is not recovered. The system resets neurons on the same `rst`.

## Timing
- Accept to `nrn_valid`/`nrn_data`: 1 cycle.
- WAIT entry: the cycle after the last accept.
- Last flag set to `out_valid`=1: 1 cycle (DRAIN entry).
- Each accepted output advances `out_data` on the next cycle. With `out_ready` held at 1, the block sustains one activation per cycle.
- Last output accept to `done` pulse and IDLE: 1 cycle. `in_ready` is 1 in that same cycle.
- Minimum frame period is `numWeight` + neuron latency + `numNeuron` + 2 cycles.
- `busy` is registered together with the state.

## Structure
- **Package `fnn_ctrl_pkg`**:
  - state enum `seq_state_t` {IDLE, STREAM, WAIT, DRAIN};
  - localparam width helpers for counter widths.
- **Sub-module `layer_result_buf`**:
  - per-neuron capture registers plus sticky flags;
  - `all_got` output;
  - read mux on `idx`;
  - clear input.
- **Top**: holds the FSM, counters and broadcast registers.

## Test plan
Bench parameters: `numWeight`=4, `numNeuron`=3, `waitTimeout`=8. Neuron models raise `outvalid` 5 cycles after their 4th input.

1. Contiguous samples 0x0001..0x0004 -> `nrn_valid` high 4 consecutive cycles, starting 1 cycle after the first accept, with matching data. `in_ready` is 0 from the cycle after the 4th accept.
2. Neurons return 0x0100, 0x0200, 0x0300 with staggered `outvalid` (k=2, then k=0 and k=1 in the same cycle) -> DRAIN outputs 0x0100, 0x0200, 0x0300 in order, followed by a `done` pulse.
3. `out_ready` toggled 1,0,0,1,1 during DRAIN -> each value holds while stalled, no value is skipped or duplicated, and `done` occurs after the 3rd accept.
4. Neuron 1 never asserts `outvalid` -> `err` pulses after 8 WAIT cycles, no `out_valid` ever asserts, and the state returns to IDLE. The next frame then completes normally.
5. `in_valid` pattern 1,0,1,0,1,1 -> exactly 4 `nrn_valid` pulses, gaps preserved. An `outvalid` injected during STREAM is ignored.
6. `rst` asserted after the 2nd sample -> next cycle all outputs hold their reset values and `busy`=0. A fresh 4-sample frame then streams and completes.
